// File: rtl/ram_set_ctrl_pkg.sv
// Shared constants and helpers for the ram_set_ctrl flow controller.
// Optional watermark ports are enabled with RAM_SET_CTRL_WATERMARK_EN.
package ram_set_ctrl_pkg;

    localparam int OBUF_DEPTH    = 2;
    localparam int REQ_IDX_W     = 3;   // wide enough for up to 8 requesters
    localparam int RAM_DEPTH_DEF = 16;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W = lvl_w(RAM_DEPTH_DEF);

endpackage

// File: rtl/ram_set_ctrl_if.sv
// Requester, RAM-port and consumer signals of ram_set_ctrl bundled in one interface.
// slave = controller side, master = the surrounding requesters/RAM/consumer.
interface ram_set_ctrl_if #(
    parameter int NUM_REQ   = 4,
    parameter int RAM_WIDTH = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*RAM_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         ram_wr_en;
    logic [RAM_WIDTH-1:0]         ram_data_in;
    logic                         ram_rd_en;
    logic [RAM_WIDTH-1:0]         ram_data_out;
    logic                         out_valid;
    logic [RAM_WIDTH-1:0]         out_data;
    logic                         out_ready;
    logic                         full;
    logic                         empty;

    modport slave (
        input  req_valid, req_data, ram_data_out, out_ready,
        output req_ready, ram_wr_en, ram_data_in, ram_rd_en,
               out_valid, out_data, full, empty
    );

    modport master (
        output req_valid, req_data, ram_data_out, out_ready,
        input  req_ready, ram_wr_en, ram_data_in, ram_rd_en,
               out_valid, out_data, full, empty
    );
endinterface

// File: rtl/ram_set_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after rr_ptr,
// and moves rr_ptr just past the winner only when a grant is issued.
module rr_arbiter
    import ram_set_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 en,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [REQ_IDX_W-1:0] gnt_idx
);
    localparam logic [REQ_IDX_W:0] N_EXT = (REQ_IDX_W+1)'(NUM_REQ);

    logic [REQ_IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [REQ_IDX_W-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;
    logic                 found;

    // Candidate gi is the requester gi places after rr_ptr, wrapped mod NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [REQ_IDX_W:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + (REQ_IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= N_EXT) ? REQ_IDX_W'(sum - N_EXT) : REQ_IDX_W'(sum);
            assign cand_hit[gi] = |(req & (NUM_REQ'(1) << cand_idx[gi]));
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (en && !found && cand_hit[k]) begin
                found   = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
        gnt = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (found) begin
            rr_ptr_next = (gnt_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + REQ_IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_reg <= '0;
        else     rr_ptr_reg <= rr_ptr_next;
    end

endmodule

// File: rtl/ram_set_ctrl.sv
// Flow controller in front of dual_port_ram_set: write arbitration, read pacing
// and a 2-entry output buffer. Optional RAM_SET_CTRL_WATERMARK_EN adds level/hwm ports.
module ram_set_ctrl
    import ram_set_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_set_ctrl_if.slave            bus
`ifdef RAM_SET_CTRL_WATERMARK_EN
    ,
    output logic [$clog2(RAM_DEPTH):0] level_o,
    output logic [$clog2(RAM_DEPTH):0] hwm_o,
    input  logic                       hwm_clr
`endif
);
    localparam int LW  = lvl_w(RAM_DEPTH);
    localparam int OCW = $clog2(OBUF_DEPTH + 1);
    localparam int OPW = $clog2(OBUF_DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(RAM_DEPTH);

    logic [NUM_REQ-1:0]   gnt;
    logic [REQ_IDX_W-1:0] gnt_idx;
    logic                 full, empty, wr, rd, pop, push;
    logic [LW-1:0]        level_reg, level_next;
    logic                 inflight_reg;
    logic [RAM_WIDTH-1:0] obuf_reg [OBUF_DEPTH];
    logic [OPW-1:0]       head_reg, tail;
    logic [OCW-1:0]       cnt_reg, cnt_next;
    logic [OCW:0]         occ;

    assign full  = (level_reg == LVL_FULL);
    assign empty = (level_reg == '0);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .en      (!full),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign wr              = |gnt;
    assign bus.req_ready   = gnt;
    assign bus.ram_wr_en   = wr;
    assign bus.ram_data_in = bus.req_data[gnt_idx*RAM_WIDTH +: RAM_WIDTH];

    // Read only when the buffer can absorb the word after everything already in flight.
    assign pop  = bus.out_valid & bus.out_ready;
    assign occ  = {1'b0, cnt_reg} + (OCW+1)'(inflight_reg) - (OCW+1)'(pop);
    assign rd   = !empty && (occ < (OCW+1)'(2));
    assign push = inflight_reg;

    assign tail       = head_reg + OPW'(cnt_reg);
    assign cnt_next   = cnt_reg + OCW'(push) - OCW'(pop);
    assign level_next = level_reg + LW'(wr) - LW'(rd);

    assign bus.ram_rd_en = rd;
    assign bus.out_valid = (cnt_reg != '0);
    assign bus.out_data  = obuf_reg[head_reg];
    assign bus.full      = full;
    assign bus.empty     = empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg    <= '0;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            cnt_reg      <= '0;
            for (int k = 0; k < OBUF_DEPTH; k++) obuf_reg[k] <= '0;
        end else begin
            level_reg    <= level_next;
            inflight_reg <= rd;
            cnt_reg      <= cnt_next;
            if (pop)  head_reg       <= head_reg + OPW'(1);
            if (push) obuf_reg[tail] <= bus.ram_data_out;
        end
    end

`ifdef RAM_SET_CTRL_WATERMARK_EN
    logic [LW-1:0] hwm_reg;

    always_ff @(posedge clk) begin
        if (rst)                      hwm_reg <= '0;
        else if (hwm_clr)             hwm_reg <= level_reg;
        else if (level_reg > hwm_reg) hwm_reg <= level_reg;
    end

    assign level_o = level_reg;
    assign hwm_o   = hwm_reg;
`endif

endmodule

// File: tb/tb_ram_set_ctrl.sv
// Randomized and directed bench for ram_set_ctrl with a queue-based reference
// model and a behavioural dual_port_ram_set stand-in.
module tb_ram_set_ctrl;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_set_ctrl_if #(.NUM_REQ(NR), .RAM_WIDTH(W)) bus ();

`ifdef RAM_SET_CTRL_WATERMARK_EN
    logic [4:0] level_o, hwm_o;
    logic       hwm_clr = 1'b0;
`endif

    ram_set_ctrl #(.NUM_REQ(NR), .RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RAM_SET_CTRL_WATERMARK_EN
        ,
        .level_o (level_o),
        .hwm_o   (hwm_o),
        .hwm_clr (hwm_clr)
`endif
    );

    // RAM stand-in: one-cycle registered read, pointers reset by ~rst_n = rst.
    logic [W-1:0] ram_mem [D];
    logic [3:0]   ram_wp, ram_rp;
    always @(posedge clk) begin
        if (rst) begin
            ram_wp <= '0;
            ram_rp <= '0;
        end else begin
            if (bus.ram_wr_en) begin
                ram_mem[ram_wp] <= bus.ram_data_in;
                ram_wp          <= ram_wp + 4'd1;
            end
            if (bus.ram_rd_en) begin
                bus.ram_data_out <= ram_mem[ram_rp];
                ram_rp           <= ram_rp + 4'd1;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words in RAM, the word in flight, words in the output buffer.
    logic [W-1:0] m_ram[$];
    logic [W-1:0] m_obuf[$];
    bit           m_infl = 0;
    logic [W-1:0] m_infl_data;
    int           m_ptr = 0;
    bit           m_fresh = 1;
    int           e_gidx, p_gidx = -1;
    logic [NR-1:0] e_gnt;
    bit           e_pop, e_rd, p_pop = 0, p_rd = 0, p_rst = 1;
    logic [W-1:0] p_wdata;
    int           n_acc = 0, n_pop = 0;

    always @(negedge clk) begin
        // Retire the transition of the previous cycle.
        if (p_rst) begin
            m_ram.delete();
            m_obuf.delete();
            m_infl  = 0;
            m_ptr   = 0;
            m_fresh = 1;
        end else begin
            if (p_pop) void'(m_obuf.pop_front());
            if (m_infl) begin
                m_obuf.push_back(m_infl_data);
                m_fresh = 0;
            end
            m_infl = p_rd;
            if (p_rd) m_infl_data = m_ram.pop_front();
            if (p_gidx >= 0) begin
                m_ram.push_back(p_wdata);
                m_ptr = (p_gidx + 1) % NR;
            end
            check("obuf_bound", m_obuf.size() <= 2, 1);
        end

        // Predict the current cycle.
        e_gidx = -1;
        e_gnt  = '0;
        if (m_ram.size() != D) begin
            for (int k = 0; k < NR; k++)
                if (e_gidx < 0 && bus.req_valid[(m_ptr + k) % NR]) e_gidx = (m_ptr + k) % NR;
        end
        if (e_gidx >= 0) e_gnt[e_gidx] = 1'b1;
        e_pop = (m_obuf.size() != 0) && bus.out_ready;
        e_rd  = (m_ram.size() != 0) && ((m_obuf.size() + int'(m_infl) - int'(e_pop)) < 2);

        check("empty", bus.empty, m_ram.size() == 0);
        check("full", bus.full, m_ram.size() == D);
        check("req_ready", bus.req_ready, e_gnt);
        check("ram_wr_en", bus.ram_wr_en, e_gidx >= 0);
        check("ram_rd_en", bus.ram_rd_en, e_rd);
        check("out_valid", bus.out_valid, m_obuf.size() != 0);
        if (m_obuf.size() != 0) check("out_data", bus.out_data, m_obuf[0]);
        else if (m_fresh)       check("out_data_rst", bus.out_data, 0);
        if (e_gidx >= 0) check("ram_data_in", bus.ram_data_in, bus.req_data[e_gidx*W +: W]);

        if (|(bus.req_valid & bus.req_ready)) n_acc++;
        if (bus.out_valid && bus.out_ready)   n_pop++;

        p_gidx  = e_gidx;
        p_pop   = e_pop;
        p_rd    = e_rd;
        p_rst   = rst;
        p_wdata = (e_gidx >= 0) ? bus.req_data[e_gidx*W +: W] : '0;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < NR; k++) bus.req_data[k*W +: W] = $urandom;
    endtask

    initial begin
        int lat, start, lmax;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);

        // First-word latency through an idle pipeline.
        bus.req_data[2*W +: W] = 32'hA5A5_0001;
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.req_valid = '0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            cyc(1);
            lat++;
        end
        check("latency", lat, 3);
        check("latency_data", bus.out_data, 32'hA5A5_0001);
        cyc(1);
        check("after_pop_valid", bus.out_valid, 0);
        check("after_pop_empty", bus.empty, 1);

        // Fill with a stalled consumer: 16 in RAM plus 2 parked in the buffer.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        start = n_acc;
        for (int i = 0; i < 60 && !bus.full; i++) begin
            rand_data();
            cyc(1);
        end
        check("fill_full", bus.full, 1);
        check("fill_grants", n_acc - start, 18);

        // One pop from full frees exactly one write slot.
        start = n_acc;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        cyc(6);
        check("one_grant", n_acc - start, 1);

        // Drain and confirm nothing was lost.
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && (bus.out_valid || !bus.empty); i++) cyc(1);
        cyc(2);
        check("no_loss", n_pop, n_acc);

        // Sustained single-requester stream.
        bus.req_valid = 4'b0001;
        cyc(10);
        start = n_pop;
        lmax  = 0;
        for (int i = 0; i < 40; i++) begin
            rand_data();
            cyc(1);
            if (int'(dut.level_reg) > lmax) lmax = int'(dut.level_reg);
        end
        check("throughput", n_pop - start, 40);
        check("level_max_le2", lmax <= 2, 1);
        bus.req_valid = '0;
        cyc(10);

        // Reset while level=7 with a read in flight.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        for (int i = 0; i < 60 && dut.level_reg != 7; i++) begin
            rand_data();
            cyc(1);
        end
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        bus.req_valid = '0;
        check("pre_rst_level", dut.level_reg, 7);
        check("pre_rst_inflight", dut.inflight_reg, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_empty", bus.empty, 1);
        check("mid_rst_level", dut.level_reg, 0);
        check("mid_rst_inflight", dut.inflight_reg, 0);
        bus.req_data[1*W +: W] = 32'h0000_1234;
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.req_valid = '0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) cyc(1);
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_data", bus.out_data, 32'h0000_1234);
        cyc(3);

        // Random traffic with varying consumer duty and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid = NR'($urandom);
            rand_data();
            if (i < 1000)      bus.out_ready = ($urandom_range(0, 3) == 0);
            else if (i < 2000) bus.out_ready = ($urandom_range(0, 3) != 0);
            else               bus.out_ready = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        rst = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        cyc(40);
        check("final_empty", bus.empty, 1);
        check("final_out_valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
